// File: rtl/mano_ac_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mano_ac_unit_if
// Purpose  : Bus bundle between the Mano accumulator unit and its
//            environment: instruction/sequence-counter/data inputs on one
//            side, AC/E/control pulses on the other.
// Signals  : IN_IR[15:0]   instruction register (I=15, opcode=14:12, B=11:0)
//            t[2:0]        sequence counter value
//            DR_IN         memory operand (WIDTH bits)
//            INPR_IN[7:0]  input character register
//            Q_AC, Q_E     accumulator and carry/link flip-flop
//            SKIP, HALT    PC-increment pulse, sticky halt flag
//            OUT_LD        load-OUTR pulse
// Modports : master drives instruction/operand inputs; slave is the unit.
// Revision : 1.0  initial release
// ============================================================================
interface mano_ac_unit_if #(
  parameter int WIDTH = 16
);
  logic [15:0]      IN_IR;
  logic [2:0]       t;
  logic [WIDTH-1:0] DR_IN;
  logic [7:0]       INPR_IN;
  logic [WIDTH-1:0] Q_AC;
  logic             Q_E;
  logic             SKIP;
  logic             HALT;
  logic             OUT_LD;

  modport master (
    output IN_IR, t, DR_IN, INPR_IN,
    input  Q_AC, Q_E, SKIP, HALT, OUT_LD
  );

  modport slave (
    input  IN_IR, t, DR_IN, INPR_IN,
    output Q_AC, Q_E, SKIP, HALT, OUT_LD
  );
endinterface
`default_nettype wire

// File: rtl/mano_ac_unit.sv
`default_nettype none
// ============================================================================
// Module   : mano_ac_unit
// Purpose  : Accumulator unit of the Mano basic computer. Holds AC and E and
//            executes AND/ADD/LDA (at T5), the twelve register-reference
//            operations (at T3), and optionally INP/OUT (at T3).
// Ports    : CLK  system clock, rising edge
//            RST  asynchronous active-high reset
//            bus  mano_ac_unit_if.slave (IN_IR, t, DR_IN, INPR_IN in;
//                 Q_AC, Q_E, SKIP, HALT, OUT_LD out)
// Config   : define MANO_AC_IO_EN to enable INP/OUT; otherwise I/O
//            instructions do nothing and OUT_LD is tied 0.
// Params   : WIDTH  data width of AC and DR_IN (8..32), must match bus.
// Revision : 1.0  initial release
// ============================================================================
module mano_ac_unit #(
  parameter int WIDTH = 16
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  mano_ac_unit_if.slave    bus
);

  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d;
  logic             skip_q, skip_d;
  logic             halt_q, halt_d;
  logic             out_ld_q, out_ld_d;

  logic        ir_i;
  logic [2:0]  opcode;
  logic [11:0] b_field;
  logic [7:0]  d_dec;
  logic        t3, t5;
  logic        r_ref;
  logic        p_io;

  assign ir_i    = bus.IN_IR[15];
  assign opcode  = bus.IN_IR[14:12];
  assign b_field = bus.IN_IR[11:0];
  assign d_dec   = 8'd1 << opcode;
  assign t3      = (bus.t == 3'd3);
  assign t5      = (bus.t == 3'd5);
  assign r_ref   = d_dec[7] & ~ir_i & t3;
  assign p_io    = d_dec[7] &  ir_i & t3;

`ifndef MANO_AC_IO_EN
  // Without the I/O feature these inputs are deliberately ignored.
  logic unused_io;
  assign unused_io = ^{bus.INPR_IN, p_io};
`endif

  always_comb begin
    ac_d     = ac_q;
    e_d      = e_q;
    skip_d   = 1'b0;
    halt_d   = halt_q;
    out_ld_d = 1'b0;

    // A halted unit freezes AC/E; SKIP and OUT_LD simply stay low.
    if (!halt_q) begin
      if (t5) begin
        unique case (opcode)
          3'd0:    ac_d = ac_q & bus.DR_IN;
          3'd1:    {e_d, ac_d} = {1'b0, ac_q} + {1'b0, bus.DR_IN};
          3'd2:    ac_d = bus.DR_IN;
          default: ;
        endcase
      end

      if (r_ref) begin
        // Highest set bit of B selects the single operation executed.
        priority casez (b_field)
          12'b1???_????_????: ac_d = '0;
          12'b01??_????_????: e_d  = 1'b0;
          12'b001?_????_????: ac_d = ~ac_q;
          12'b0001_????_????: e_d  = ~e_q;
          12'b0000_1???_????: begin
            ac_d = {e_q, ac_q[WIDTH-1:1]};
            e_d  = ac_q[0];
          end
          12'b0000_01??_????: begin
            ac_d = {ac_q[WIDTH-2:0], e_q};
            e_d  = ac_q[WIDTH-1];
          end
          12'b0000_001?_????: ac_d   = ac_q + 1'b1;
          12'b0000_0001_????: skip_d = ~ac_q[WIDTH-1];
          12'b0000_0000_1???: skip_d =  ac_q[WIDTH-1];
          12'b0000_0000_01??: skip_d = (ac_q == '0);
          12'b0000_0000_001?: skip_d = ~e_q;
          12'b0000_0000_0001: halt_d = 1'b1;
          default: ;
        endcase
      end

`ifdef MANO_AC_IO_EN
      if (p_io) begin
        if (b_field[11]) begin
          ac_d = {{(WIDTH-8){1'b0}}, bus.INPR_IN};
        end else if (b_field[10]) begin
          out_ld_d = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ac_q     <= '0;
      e_q      <= 1'b0;
      skip_q   <= 1'b0;
      halt_q   <= 1'b0;
      out_ld_q <= 1'b0;
    end else begin
      ac_q     <= ac_d;
      e_q      <= e_d;
      skip_q   <= skip_d;
      halt_q   <= halt_d;
      out_ld_q <= out_ld_d;
    end
  end

  assign bus.Q_AC   = ac_q;
  assign bus.Q_E    = e_q;
  assign bus.SKIP   = skip_q;
  assign bus.HALT   = halt_q;
  assign bus.OUT_LD = out_ld_q;

endmodule
`default_nettype wire

// File: tb/tb_mano_ac_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mano_ac_unit
// Purpose  : Directed self-checking bench for mano_ac_unit at WIDTH=16.
//            Expected values are hand-computed constants; I/O expectations
//            follow MANO_AC_IO_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_mano_ac_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mano_ac_unit_if #(.WIDTH(16)) bus ();

  mano_ac_unit #(.WIDTH(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one instruction for one rising edge, then park t on a no-op code.
  task automatic step(input logic [15:0] ir, input logic [2:0] tt,
                      input logic [15:0] dr);
    @(negedge clk);
    bus.IN_IR = ir;
    bus.t     = tt;
    bus.DR_IN = dr;
    @(posedge clk);
    #1;
    bus.t = 3'd6;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    bus.IN_IR   = 16'h0000;
    bus.t       = 3'd6;
    bus.DR_IN   = 16'h0000;
    bus.INPR_IN = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ac",   bus.Q_AC,   32'h0);
    chk("rst_e",    bus.Q_E,    32'h0);
    chk("rst_skip", bus.SKIP,   32'h0);
    chk("rst_halt", bus.HALT,   32'h0);
    chk("rst_out",  bus.OUT_LD, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ADD with carry out
    step(16'h2000, 3'd5, 16'hFFFF);
    chk("lda_ffff", bus.Q_AC, 32'hFFFF);
    step(16'h1000, 3'd5, 16'h0002);
    chk("add_ac", bus.Q_AC, 32'h0001);
    chk("add_e",  bus.Q_E,  32'h1);

    // AND, E untouched
    step(16'h2000, 3'd5, 16'h0F0F);
    step(16'h0000, 3'd5, 16'h00FF);
    chk("and_ac", bus.Q_AC, 32'h000F);
    chk("and_e",  bus.Q_E,  32'h1);

    // No change at t=6 or for D3
    step(16'h2000, 3'd6, 16'h1234);
    chk("t6_noop", bus.Q_AC, 32'h000F);
    step(16'h3000, 3'd5, 16'h1234);
    chk("d3_noop", bus.Q_AC, 32'h000F);

    // Rotates through E
    step(16'h2000, 3'd5, 16'h8001);
    step(16'h7400, 3'd3, 16'h0000);
    chk("cle_e", bus.Q_E, 32'h0);
    step(16'h7040, 3'd3, 16'h0000);
    chk("cil_ac", bus.Q_AC, 32'h0002);
    chk("cil_e",  bus.Q_E,  32'h1);
    step(16'h7080, 3'd3, 16'h0000);
    chk("cir_ac", bus.Q_AC, 32'h8001);
    chk("cir_e",  bus.Q_E,  32'h0);

    // Complements
    step(16'h7200, 3'd3, 16'h0000);
    chk("cma_ac", bus.Q_AC, 32'h7FFE);
    step(16'h7100, 3'd3, 16'h0000);
    chk("cme_e", bus.Q_E, 32'h1);

    // Skips (E=1 here)
    step(16'h7800, 3'd3, 16'h0000);
    chk("cla_ac", bus.Q_AC, 32'h0000);
    step(16'h7004, 3'd3, 16'h0000);
    chk("sza_zero", bus.SKIP, 32'h1);
    step(16'h0000, 3'd6, 16'h0000);
    chk("skip_drop", bus.SKIP, 32'h0);
    step(16'h2000, 3'd5, 16'h0005);
    step(16'h7004, 3'd3, 16'h0000);
    chk("sza_nz", bus.SKIP, 32'h0);
    step(16'h7010, 3'd3, 16'h0000);
    chk("spa_pos", bus.SKIP, 32'h1);
    step(16'h7008, 3'd3, 16'h0000);
    chk("sna_pos", bus.SKIP, 32'h0);
    step(16'h7002, 3'd3, 16'h0000);
    chk("sze_e1", bus.SKIP, 32'h0);
    step(16'h7400, 3'd3, 16'h0000);
    step(16'h7002, 3'd3, 16'h0000);
    chk("sze_e0", bus.SKIP, 32'h1);

    // Priority and INC wrap (set E=1 first)
    step(16'h7100, 3'd3, 16'h0000);
    step(16'h2000, 3'd5, 16'hFFFF);
    step(16'h7820, 3'd3, 16'h0000);
    chk("cla_prio", bus.Q_AC, 32'h0000);
    step(16'h2000, 3'd5, 16'hFFFF);
    step(16'h7020, 3'd3, 16'h0000);
    chk("inc_wrap", bus.Q_AC, 32'h0000);
    chk("inc_e",    bus.Q_E,  32'h1);

    // Input-output
    step(16'h2000, 3'd5, 16'hABCD);
    bus.INPR_IN = 8'h5A;
    step(16'hF800, 3'd3, 16'h0000);
`ifdef MANO_AC_IO_EN
    chk("inp_ac", bus.Q_AC, 32'h005A);
`else
    chk("inp_ac", bus.Q_AC, 32'hABCD);
`endif
    step(16'h2000, 3'd5, 16'hABCD);
    step(16'hF400, 3'd3, 16'h0000);
`ifdef MANO_AC_IO_EN
    chk("out_ld", bus.OUT_LD, 32'h1);
`else
    chk("out_ld", bus.OUT_LD, 32'h0);
`endif
    chk("out_ac", bus.Q_AC, 32'hABCD);
    step(16'h0000, 3'd6, 16'h0000);
    chk("out_drop", bus.OUT_LD, 32'h0);

    // Halt freezes everything until reset
    step(16'h7001, 3'd3, 16'h0000);
    chk("halt_set", bus.HALT, 32'h1);
    step(16'h2000, 3'd5, 16'h1234);
    chk("halt_lda", bus.Q_AC, 32'hABCD);
    step(16'h7008, 3'd3, 16'h0000);
    chk("halt_skip", bus.SKIP, 32'h0);
    step(16'h7100, 3'd3, 16'h0000);
    chk("halt_e", bus.Q_E, 32'h1);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ac",   bus.Q_AC, 32'h0);
    chk("arst_e",    bus.Q_E,  32'h0);
    chk("arst_halt", bus.HALT, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(16'h2000, 3'd5, 16'h1234);
    chk("post_rst_lda", bus.Q_AC, 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
